// File: rtl/copy_job_arbiter.sv
// copy_job_arbiter: round-robin owner of the shared array-copy engine.
// Drives the engine Start/Ack handshake, counts jobs, guards run time.
module copy_job_arbiter #(
    parameter int TMAX = 64,
    parameter int TW   = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Req0,
    input  logic       Req1,
    output logic       Gnt0,
    output logic       Gnt1,
    output logic       Done0,
    output logic       Done1,
    output logic       Eng_Start,
    output logic       Eng_Ack,
    input  logic       Eng_Done,
    output logic [7:0] Jobs0,
    output logic [7:0] Jobs1,
    output logic       Err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_RUN     = 3'd2,
        S_ACK     = 3'd3,
        S_WAITREL = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam logic [TW-1:0] WD_LIM = TW'(TMAX - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [TW-1:0] wd_q, wd_d;
    logic [7:0]    jobs0_q, jobs1_q;
    logic          err_q, err_d;
    logic          busy;
    logic          own_req;
    logic          inc0, inc1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wd_q    <= '0;
            jobs0_q <= 8'd0;
            jobs1_q <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            jobs0_q <= Jobs0;
            jobs1_q <= Jobs1;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        wd_d      = wd_q;
        err_d     = err_q;
        busy      = 1'b0;
        Eng_Start = 1'b0;
        Eng_Ack   = 1'b0;
        Done0     = 1'b0;
        Done1     = 1'b0;
        own_req   = owner_q ? Req1 : Req0;
        case (state_q)
            S_IDLE: begin
                if (Req0 | Req1) begin
                    state_d = S_START;
                    wd_d    = '0;
                end
                unique case (1'b1)
                    Req0 & ~Req1: owner_d = 1'b0;
                    Req1 & ~Req0: owner_d = 1'b1;
                    Req0 & Req1:  owner_d = ~last_q;
                    default:      owner_d = owner_q;
                endcase
            end
            S_START: begin
                busy      = 1'b1;
                Eng_Start = 1'b1;
                state_d   = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                wd_d = wd_q + 1'b1;
                // completion wins over a timeout landing on the same edge
                if (Eng_Done) begin
                    state_d = S_ACK;
                end else if (wd_q == WD_LIM) begin
                    state_d = S_FAULT;
                    err_d   = 1'b1;
                end
            end
            S_ACK: begin
                busy    = 1'b1;
                Eng_Ack = 1'b1;
                Done0   = ~owner_q;
                Done1   = owner_q;
                last_d  = owner_q;
                state_d = S_WAITREL;
            end
            S_WAITREL: begin
                busy = 1'b1;
                if (!own_req) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Gnt0 = busy & ~owner_q;
    assign Gnt1 = busy & owner_q;

    // count shows the completed job during ACK; register follows next edge
    assign inc0  = Eng_Ack & ~owner_q & (jobs0_q != 8'hFF);
    assign inc1  = Eng_Ack & owner_q & (jobs1_q != 8'hFF);
    assign Jobs0 = jobs0_q + {7'd0, inc0};
    assign Jobs1 = jobs1_q + {7'd0, inc1};
    assign Err   = err_q;

endmodule

// File: tb/tb_copy_job_arbiter.sv
// tb_copy_job_arbiter: vectors, directed corner sequences and a
// randomized run against a transaction-level arbiter model.
module tb_copy_job_arbiter;

    localparam int TMAX = 64;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Req0, Req1, Eng_Done;
    logic       Gnt0, Gnt1, Done0, Done1;
    logic       Eng_Start, Eng_Ack, Err;
    logic [7:0] Jobs0, Jobs1;

    int tests = 0;
    int fails = 0;

    int eng_lat  = 1;
    int eng_cnt  = 0;
    bit eng_busy = 0;
    bit eng_hang = 0;
    bit eng_rand = 0;

    typedef struct {
        bit r0;
        bit r1;
        int lat;
        int owner;
        int j0;
        int j1;
    } vec_t;

    vec_t vt[8];

    copy_job_arbiter #(.TMAX(TMAX), .TW(8)) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .Req0(Req0),
        .Req1(Req1),
        .Gnt0(Gnt0),
        .Gnt1(Gnt1),
        .Done0(Done0),
        .Done1(Done1),
        .Eng_Start(Eng_Start),
        .Eng_Ack(Eng_Ack),
        .Eng_Done(Eng_Done),
        .Jobs0(Jobs0),
        .Jobs1(Jobs1),
        .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // engine model: Done rises eng_lat cycles after Start, falls on Ack
    always begin
        @(posedge Clk);
        #2;
        if (!Reset_n) begin
            Eng_Done = 1'b0;
            eng_busy = 1'b0;
        end else if (Eng_Ack) begin
            Eng_Done = 1'b0;
            eng_busy = 1'b0;
        end else if (Eng_Start) begin
            eng_busy = 1'b1;
            eng_cnt  = eng_rand ? int'($urandom_range(20, 1)) : eng_lat;
        end else if (eng_busy && !Eng_Done && !eng_hang) begin
            if (eng_cnt <= 1) Eng_Done = 1'b1;
            else eng_cnt--;
        end
    end

    always @(negedge Clk) begin
        chk("gnt_exclusive", {31'd0, Gnt0 & Gnt1}, 0);
    end

    function automatic bit cond(input int which);
        case (which)
            0:       return Eng_Start;
            1:       return Done0 | Done1;
            default: return !(Gnt0 | Gnt1);
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit,
                            input string name);
        int n;
        n = 0;
        tick();
        while (!cond(which) && n < limit) begin
            tick();
            n++;
        end
        chk(name, {31'd0, cond(which)}, 1);
    endtask

    task automatic do_reset();
        Req0     = 1'b0;
        Req1     = 1'b0;
        eng_hang = 1'b0;
        eng_rand = 1'b0;
        Reset_n  = 1'b0;
        tick();
        chk("rst_gnt", {Gnt0, Gnt1, Eng_Start, Eng_Ack, Done0, Done1}, 0);
        chk("rst_jobs", {Jobs0, Jobs1}, 0);
        chk("rst_err", Err, 0);
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic run_job(input bit r0, input bit r1, input int lat,
                           output int owner);
        int n;
        eng_lat = lat;
        Req0 = r0;
        Req1 = r1;
        tick();
        chk("req_to_start", Eng_Start, 1);
        chk("start_grant", Gnt0 | Gnt1, 1);
        owner = Gnt1 ? 1 : 0;
        tick();
        chk("start_one_cycle", Eng_Start, 0);
        n = 0;
        while (!(Done0 | Done1) && n < lat + 8) begin
            tick();
            n++;
        end
        chk("job_done_seen", Done0 | Done1, 1);
        chk("done_owner", Done1, owner);
        chk("ack_with_done", Eng_Ack, 1);
        chk("ack_latency", n, lat);
        chk("no_err", Err, 0);
        Req0 = 1'b0;
        Req1 = 1'b0;
        tick();
        chk("done_one_cycle", {Done0, Done1, Eng_Ack}, 0);
        chk("waitrel_hold", owner ? Gnt1 : Gnt0, 1);
        tick();
        chk("released", Gnt0 | Gnt1, 0);
    endtask

    task automatic random_run(input int cycles);
        int owner_m, last_m;
        int cnt[2];
        bit jdone, inwr, ped;
        bit pr[2], g[2], d[2], rq[2], seen[2];
        owner_m = -1;
        last_m  = 1;
        cnt[0]  = 0;
        cnt[1]  = 0;
        jdone   = 0;
        inwr    = 0;
        rq[0]   = 0;
        rq[1]   = 0;
        seen[0] = 0;
        seen[1] = 0;
        eng_rand = 1'b1;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge Clk);
            pr[0] = Req0;
            pr[1] = Req1;
            ped   = Eng_Done;
            tick();
            g[0] = Gnt0;
            g[1] = Gnt1;
            d[0] = Done0;
            d[1] = Done1;
            if (owner_m < 0) begin
                chk("rm_idle_ack", {Eng_Ack, d[0], d[1]}, 0);
                if (pr[0] | pr[1]) begin
                    owner_m = (pr[0] & pr[1]) ? 1 - last_m : (pr[0] ? 0 : 1);
                    jdone = 0;
                    inwr  = 0;
                    chk("rm_start", Eng_Start, 1);
                    chk("rm_gnt", g[owner_m], 1);
                end else begin
                    chk("rm_idle_start", Eng_Start, 0);
                    chk("rm_idle_gnt", g[0] | g[1], 0);
                end
            end else begin
                chk("rm_start_once", Eng_Start, 0);
                if (!jdone && ped) begin
                    if (cnt[owner_m] < 255) cnt[owner_m]++;
                    last_m = owner_m;
                    jdone  = 1;
                    chk("rm_ack", {Eng_Ack, d[owner_m], d[1-owner_m]}, 3'b110);
                    chk("rm_ack_gnt", g[owner_m], 1);
                end else begin
                    chk("rm_no_ack", {Eng_Ack, d[0], d[1]}, 0);
                    if (inwr && !pr[owner_m]) begin
                        owner_m = -1;
                        chk("rm_release", g[0] | g[1], 0);
                    end else begin
                        if (jdone) inwr = 1;
                        chk("rm_hold", g[owner_m], 1);
                    end
                end
            end
            chk("rm_jobs0", Jobs0, cnt[0]);
            chk("rm_jobs1", Jobs1, cnt[1]);
            chk("rm_err", Err, 0);
            for (int c = 0; c < 2; c++) begin
                if (d[c]) seen[c] = 1;
                if (!rq[c]) begin
                    if ($urandom_range(3, 0) == 0) begin
                        rq[c]   = 1;
                        seen[c] = 0;
                    end
                end else if (seen[c]) begin
                    if ($urandom_range(1, 0) == 0) rq[c] = 0;
                end else if ($urandom_range(63, 0) == 0) begin
                    rq[c] = 0;
                end
            end
            Req0 = rq[0];
            Req1 = rq[1];
        end
        eng_rand = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int own;
        int n;
        Reset_n  = 1'b0;
        Req0     = 1'b0;
        Req1     = 1'b0;
        Eng_Done = 1'b0;

        vt[0] = '{1'b1, 1'b0, 12, 0, 1, 0};
        vt[1] = '{1'b1, 1'b1,  3, 1, 1, 1};
        vt[2] = '{1'b1, 1'b1,  5, 0, 2, 1};
        vt[3] = '{1'b1, 1'b1,  1, 1, 2, 2};
        vt[4] = '{1'b0, 1'b1,  7, 1, 2, 3};
        vt[5] = '{1'b1, 1'b1,  2, 0, 3, 3};
        vt[6] = '{1'b1, 1'b0, 64, 0, 4, 3};
        vt[7] = '{1'b1, 1'b1,  4, 1, 4, 4};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_job(vt[i].r0, vt[i].r1, vt[i].lat, own);
            chk("vec_owner", own, vt[i].owner);
            chk("vec_jobs0", Jobs0, vt[i].j0);
            chk("vec_jobs1", Jobs1, vt[i].j1);
        end

        // both clients held high: strict alternation from reset
        do_reset();
        eng_lat = 6;
        Req0 = 1'b1;
        Req1 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_for(0, 20, "rr_start");
            own = Gnt1 ? 1 : 0;
            chk("rr_order", own, j % 2);
            wait_for(1, 40, "rr_done");
            if (j == 3) begin
                Req0 = 1'b0;
                Req1 = 1'b0;
            end else if (own == 1) begin
                Req1 = 1'b0;
            end else begin
                Req0 = 1'b0;
            end
            wait_for(2, 10, "rr_release");
            if (j < 3) begin
                if (own == 1) Req1 = 1'b1;
                else Req0 = 1'b1;
            end
        end
        chk("rr_jobs0", Jobs0, 2);
        chk("rr_jobs1", Jobs1, 2);

        // late requester waits out the whole job and the release
        eng_lat = 10;
        Req0 = 1'b1;
        wait_for(0, 5, "late_start");
        chk("late_gnt0", Gnt0, 1);
        tick();
        tick();
        Req1 = 1'b1;
        n = 0;
        while (!Done0 && n < 30) begin
            tick();
            chk("late_ignored", Gnt1, 0);
            n++;
        end
        chk("late_done0", Done0, 1);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("late_waitrel", {Gnt0, Gnt1}, 2'b10);
        end
        Req0 = 1'b0;
        tick();
        chk("late_idle", Gnt0 | Gnt1, 0);
        tick();
        chk("late_gnt1", {Gnt1, Eng_Start}, 2'b11);
        wait_for(1, 30, "late_done1");
        Req1 = 1'b0;
        wait_for(2, 10, "late_release");

        // watchdog: engine never finishes
        do_reset();
        eng_hang = 1'b1;
        Req0 = 1'b1;
        tick();
        chk("wd_start", Eng_Start, 1);
        for (int i = 0; i < TMAX; i++) tick();
        chk("wd_not_yet", {Err, Gnt0}, 2'b01);
        tick();
        chk("wd_fault", {Err, Gnt0, Gnt1}, 3'b100);
        Req0 = 1'b0;
        tick();
        Req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("wd_no_grant", {Gnt0, Gnt1, Eng_Start, Eng_Ack}, 0);
            chk("wd_err_sticky", Err, 1);
        end
        do_reset();
        chk("wd_err_cleared", Err, 0);

        // saturation of the client-0 counter
        for (int i = 1; i <= 257; i++) begin
            run_job(1'b1, 1'b0, 1, own);
            chk("sat_jobs0", Jobs0, (i > 255) ? 255 : i);
        end

        // asynchronous reset in the middle of a run
        eng_lat = 30;
        Req0 = 1'b1;
        wait_for(0, 5, "mr_start");
        tick();
        tick();
        chk("mr_running", Gnt0, 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("mr_async_out", {Gnt0, Gnt1, Eng_Start, Eng_Ack, Done0, Done1, Err}, 0);
        chk("mr_async_jobs", {Jobs0, Jobs1}, 0);
        Req0 = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        run_job(1'b1, 1'b1, 2, own);
        chk("last_after_reset", own, 0);

        do_reset();
        random_run(4000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
